lv_owt_tx_arb: RTL

Arbiter/sequencer sharing the single one-wire (OWT) transmit channel between REQ_NUM register-access requesters: the LV control FSM watchdog request, SPI-forwarded HV register accesses, and periodic status scan. It grants one requester at a time, drives the OWT engine request held until response ack, and applies timeout and bounded retry. It reports per-requester ack/error and a com-error pulse feeding the fault logic. It is gated by the FSM's OWT-communication enable.

---
 rtl/lv_owt_tx_arb_pkg.sv | 23 ++
 rtl/lv_owt_tx_arb_pick.sv | 44 ++++
 rtl/lv_owt_tx_arb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lv_owt_tx_arb_pkg.sv
// Shared definitions for the OWT transmit arbiter: state encoding and default geometry.
// Optional round-robin arbitration is selected with LV_OWT_ARB_RR_EN.
package lv_owt_tx_arb_pkg;

  localparam int OWT_ARB_ST_W  = 2;
  localparam int OWT_ADDR_W    = 7;
  localparam int OWT_DATA_W    = 16;
  localparam int OWT_TMO_CYC   = 1024;
  localparam int OWT_RETRY_MAX = 3;

  typedef enum logic [OWT_ARB_ST_W-1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RETRY = 2'd2,
    DONE  = 2'd3
  } owt_arb_st_e;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lv_owt_tx_arb_pick.sv
// Combinational winner selection for the OWT arbiter: fixed priority (index 0 first)
// or, with LV_OWT_ARB_RR_EN, round-robin starting after the last grant.
module lv_owt_arb_pick #(
  parameter int REQ_NUM = 3
) (
  input  logic [REQ_NUM-1:0]         i_req,
`ifdef LV_OWT_ARB_RR_EN
  input  logic [$clog2(REQ_NUM)-1:0] i_ptr,
`endif
  output logic                       o_valid,
  output logic [REQ_NUM-1:0]         o_grant,
  output logic [$clog2(REQ_NUM)-1:0] o_idx
);

  localparam int IDX_W = $clog2(REQ_NUM);

  // First asserted request in search order wins.
  always_comb begin
    int k;
    o_valid = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    k       = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
`ifdef LV_OWT_ARB_RR_EN
      k = (int'(i_ptr) + 1 + i) % REQ_NUM;
`else
      k = i;
`endif
      if (!o_valid && i_req[k]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(k);
      end else begin
        o_idx = o_idx;
      end
    end
    if (o_valid) begin
      o_grant[o_idx] = 1'b1;
    end else begin
      o_grant = '0;
    end
  end

endmodule

// File: rtl/lv_owt_tx_arb.sv
// Shares the single OWT transmit channel between REQ_NUM requesters with timeout and
// bounded retry. Define LV_OWT_ARB_RR_EN for round-robin instead of fixed priority.
module lv_owt_tx_arb
  import lv_owt_tx_arb_pkg::*;
#(
  parameter int REQ_NUM   = 3,
  parameter int ADDR_W    = OWT_ADDR_W,
  parameter int DATA_W    = OWT_DATA_W,
  parameter int TMO_CYC   = OWT_TMO_CYC,
  parameter int RETRY_MAX = OWT_RETRY_MAX
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_owt_com_en,
  input  logic [REQ_NUM-1:0]           i_req,
  input  logic [REQ_NUM-1:0]           i_req_wr,
  input  logic [REQ_NUM*ADDR_W-1:0]    i_req_addr,
  input  logic [REQ_NUM*DATA_W-1:0]    i_req_wdata,
  output logic [REQ_NUM-1:0]           o_req_ack,
  output logic [REQ_NUM-1:0]           o_req_err,
  output logic [DATA_W-1:0]            o_rdata,
  output logic                         o_owt_tx_req,
  output logic                         o_owt_tx_wr,
  output logic [ADDR_W-1:0]            o_owt_tx_addr,
  output logic [DATA_W-1:0]            o_owt_tx_wdata,
  input  logic                         i_owt_rx_ack,
  input  logic [DATA_W-1:0]            i_owt_rx_data,
  input  logic                         i_owt_rx_crc_err,
  output logic                         o_owt_com_err,
  output logic                         o_busy,
  output logic [$clog2(REQ_NUM)-1:0]   o_grant_id
);

  localparam int IDX_W = $clog2(REQ_NUM);
  localparam int TMO_W = cnt_w(TMO_CYC);
  localparam int RTY_W = cnt_w(RETRY_MAX + 1);

  owt_arb_st_e          r_state, w_nxt_state;
  logic [TMO_W-1:0]     r_tmo_cnt, w_nxt_tmo_cnt;
  logic [RTY_W-1:0]     r_retry_cnt, w_nxt_retry_cnt;
  logic [REQ_NUM-1:0]   r_grant_oh, w_nxt_grant_oh;
  logic [IDX_W-1:0]     r_grant_id, w_nxt_grant_id;
  logic [REQ_NUM-1:0]   r_ack, w_nxt_ack;
  logic [REQ_NUM-1:0]   r_err, w_nxt_err;
  logic [DATA_W-1:0]    r_rdata, w_nxt_rdata;
  logic                 r_tx_req, w_nxt_tx_req;
  logic                 r_tx_wr, w_nxt_tx_wr;
  logic [ADDR_W-1:0]    r_tx_addr, w_nxt_tx_addr;
  logic [DATA_W-1:0]    r_tx_wdata, w_nxt_tx_wdata;
  logic                 r_com_err, w_nxt_com_err;
  logic                 r_busy, w_nxt_busy;

  logic                 w_pick_valid;
  logic [REQ_NUM-1:0]   w_pick_oh;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_fail;

  lv_owt_arb_pick #(.REQ_NUM(REQ_NUM)) u_pick (
    .i_req   (i_req),
`ifdef LV_OWT_ARB_RR_EN
    .i_ptr   (r_grant_id),
`endif
    .o_valid (w_pick_valid),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx)
  );

  // A bad CRC or an expired timeout both count as one failed attempt; a clean ack wins.
  assign w_fail = (i_owt_rx_ack && i_owt_rx_crc_err) ||
                  (!i_owt_rx_ack && (r_tmo_cnt == TMO_W'(TMO_CYC - 1)));

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_tmo_cnt   = r_tmo_cnt;
    w_nxt_retry_cnt = r_retry_cnt;
    w_nxt_grant_oh  = r_grant_oh;
    w_nxt_grant_id  = r_grant_id;
    w_nxt_ack       = '0;
    w_nxt_err       = '0;
    w_nxt_rdata     = r_rdata;
    w_nxt_tx_req    = 1'b0;
    w_nxt_tx_wr     = r_tx_wr;
    w_nxt_tx_addr   = r_tx_addr;
    w_nxt_tx_wdata  = r_tx_wdata;
    w_nxt_com_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_owt_com_en && w_pick_valid) begin
          w_nxt_state     = REQ;
          w_nxt_tx_req    = 1'b1;
          w_nxt_tmo_cnt   = '0;
          w_nxt_retry_cnt = '0;
          w_nxt_grant_oh  = w_pick_oh;
          w_nxt_grant_id  = w_pick_idx;
          w_nxt_tx_wr     = i_req_wr[w_pick_idx];
          w_nxt_tx_addr   = i_req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
          w_nxt_tx_wdata  = i_req_wdata[int'(w_pick_idx)*DATA_W +: DATA_W];
        end else begin
          w_nxt_state = IDLE;
        end
      end
      REQ: begin
        if (!i_owt_com_en) begin
          w_nxt_state = DONE;
          w_nxt_ack   = r_grant_oh;
          w_nxt_err   = r_grant_oh;
        end else if (i_owt_rx_ack && !i_owt_rx_crc_err) begin
          w_nxt_state = DONE;
          w_nxt_ack   = r_grant_oh;
          w_nxt_rdata = i_owt_rx_data;
        end else if (w_fail) begin
          if (r_retry_cnt < RTY_W'(RETRY_MAX)) begin
            w_nxt_state     = RETRY;
            w_nxt_retry_cnt = r_retry_cnt + RTY_W'(1);
          end else begin
            w_nxt_state   = DONE;
            w_nxt_ack     = r_grant_oh;
            w_nxt_err     = r_grant_oh;
            w_nxt_com_err = 1'b1;
          end
        end else begin
          w_nxt_tx_req  = 1'b1;
          w_nxt_tmo_cnt = r_tmo_cnt + TMO_W'(1);
        end
      end
      RETRY: begin
        if (!i_owt_com_en) begin
          w_nxt_state = DONE;
          w_nxt_ack   = r_grant_oh;
          w_nxt_err   = r_grant_oh;
        end else begin
          w_nxt_state   = REQ;
          w_nxt_tx_req  = 1'b1;
          w_nxt_tmo_cnt = '0;
        end
      end
      DONE: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
    w_nxt_busy = (w_nxt_state != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_tmo_cnt   <= '0;
      r_retry_cnt <= '0;
      r_grant_oh  <= '0;
      r_grant_id  <= '0;
      r_ack       <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
      r_tx_req    <= 1'b0;
      r_tx_wr     <= 1'b0;
      r_tx_addr   <= '0;
      r_tx_wdata  <= '0;
      r_com_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_tmo_cnt   <= w_nxt_tmo_cnt;
      r_retry_cnt <= w_nxt_retry_cnt;
      r_grant_oh  <= w_nxt_grant_oh;
      r_grant_id  <= w_nxt_grant_id;
      r_ack       <= w_nxt_ack;
      r_err       <= w_nxt_err;
      r_rdata     <= w_nxt_rdata;
      r_tx_req    <= w_nxt_tx_req;
      r_tx_wr     <= w_nxt_tx_wr;
      r_tx_addr   <= w_nxt_tx_addr;
      r_tx_wdata  <= w_nxt_tx_wdata;
      r_com_err   <= w_nxt_com_err;
      r_busy      <= w_nxt_busy;
    end
  end

  assign o_req_ack      = r_ack;
  assign o_req_err      = r_err;
  assign o_rdata        = r_rdata;
  assign o_owt_tx_req   = r_tx_req;
  assign o_owt_tx_wr    = r_tx_wr;
  assign o_owt_tx_addr  = r_tx_addr;
  assign o_owt_tx_wdata = r_tx_wdata;
  assign o_owt_com_err  = r_com_err;
  assign o_busy         = r_busy;
  assign o_grant_id     = r_grant_id;

endmodule
